game_round_ctrl: RTL

Round sequencer for the Bulls and Cows game. It collects a four-digit guess from decoded keypad pulses and rejects duplicate digits. It then hands the completed guess and the latched secret to the strike/ball scorer, waits for the LCD/LED layer to show the result, and tracks attempts up to a win or lose verdict. It replaces the free-running trigger-and-shift-register chain between the keypad decoder and the scorer with an explicit handshaked state machine.

---
 rtl/game_round_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/game_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_round_ctrl
//  Description : Bulls and Cows round sequencer. Builds a four-digit guess
//                from keypad pulses (rejecting duplicates and non-BCD keys),
//                handshakes the guess with the strike/ball scorer and the
//                display layer, and tracks attempts to a win/lose verdict.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_round_ctrl #(
    parameter int MAX_TRIES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic [15:0] answer,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        key_del,
    input  logic        score_ack,
    input  logic [3:0]  strike,
    input  logic [3:0]  ball,
    input  logic        lcd_ack,
    output logic [15:0] answer_q,
    output logic [15:0] guess,
    output logic [2:0]  digit_cnt,
    output logic        score_req,
    output logic [3:0]  strike_q,
    output logic [3:0]  ball_q,
    output logic        lcd_req,
    output logic [3:0]  try_count,
    output logic        win,
    output logic        lose,
    output logic        dup_err
);

    localparam logic [3:0] c_MAX_TRIES = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_SCORE = 3'd2,
        ST_SHOW  = 3'd3,
        ST_WIN   = 3'd4,
        ST_LOSE  = 3'd5
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic [15:0] r_answer_q,  w_answer_q_nxt;
    logic [15:0] r_guess,     w_guess_nxt;
    logic [2:0]  r_digit_cnt, w_digit_cnt_nxt;
    logic        r_score_req, w_score_req_nxt;
    logic [3:0]  r_strike_q,  w_strike_q_nxt;
    logic [3:0]  r_ball_q,    w_ball_q_nxt;
    logic        r_lcd_req,   w_lcd_req_nxt;
    logic [3:0]  r_try_count, w_try_count_nxt;
    logic        r_win,       w_win_nxt;
    logic        r_lose,      w_lose_nxt;
    logic        r_dup_err,   w_dup_err_nxt;

    logic        w_key_seen;
    logic        w_key_bad;

    // Flag a key digit already present among the digits entered so far;
    // stale nibbles above digit_cnt are not considered.
    always_comb begin
        w_key_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) < r_digit_cnt) && (r_guess[4*i +: 4] == key_digit)) begin
                w_key_seen = 1'b1;
            end
        end
    end

    assign w_key_bad = w_key_seen || (key_digit > 4'd9);

    // Next-state and next-output logic; new_game pre-empts every state.
    always_comb begin
        w_state_nxt     = r_state;
        w_answer_q_nxt  = r_answer_q;
        w_guess_nxt     = r_guess;
        w_digit_cnt_nxt = r_digit_cnt;
        w_score_req_nxt = r_score_req;
        w_strike_q_nxt  = r_strike_q;
        w_ball_q_nxt    = r_ball_q;
        w_lcd_req_nxt   = r_lcd_req;
        w_try_count_nxt = r_try_count;
        w_win_nxt       = r_win;
        w_lose_nxt      = r_lose;
        w_dup_err_nxt   = 1'b0;

        if (new_game) begin
            w_state_nxt     = ST_ENTRY;
            w_answer_q_nxt  = answer;
            w_guess_nxt     = 16'h0000;
            w_digit_cnt_nxt = 3'd0;
            w_try_count_nxt = 4'd0;
            w_win_nxt       = 1'b0;
            w_lose_nxt      = 1'b0;
            w_strike_q_nxt  = 4'd0;
            w_ball_q_nxt    = 4'd0;
            w_score_req_nxt = 1'b0;
            w_lcd_req_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (key_del) begin
                        // Delete has priority over a simultaneous key.
                        if (r_digit_cnt != 3'd0) begin
                            w_guess_nxt     = r_guess >> 4;
                            w_digit_cnt_nxt = r_digit_cnt - 3'd1;
                        end
                    end else if (key_valid) begin
                        if (w_key_bad) begin
                            w_dup_err_nxt = 1'b1;
                        end else begin
                            w_guess_nxt     = {r_guess[11:0], key_digit};
                            w_digit_cnt_nxt = r_digit_cnt + 3'd1;
                            if (r_digit_cnt == 3'd3) begin
                                w_state_nxt     = ST_SCORE;
                                w_score_req_nxt = 1'b1;
                            end
                        end
                    end
                end
                ST_SCORE: begin
                    if (score_ack) begin
                        w_strike_q_nxt  = strike;
                        w_ball_q_nxt    = ball;
                        if (r_try_count != c_MAX_TRIES) begin
                            w_try_count_nxt = r_try_count + 4'd1;
                        end
                        w_score_req_nxt = 1'b0;
                        w_lcd_req_nxt   = 1'b1;
                        w_state_nxt     = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (lcd_ack) begin
                        w_lcd_req_nxt = 1'b0;
                        if (r_strike_q == 4'd4) begin
                            w_state_nxt = ST_WIN;
                            w_win_nxt   = 1'b1;
                        end else if (r_try_count == c_MAX_TRIES) begin
                            w_state_nxt = ST_LOSE;
                            w_lose_nxt  = 1'b1;
                        end else begin
                            w_state_nxt     = ST_ENTRY;
                            w_guess_nxt     = 16'h0000;
                            w_digit_cnt_nxt = 3'd0;
                        end
                    end
                end
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    // Wait for new_game.
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_answer_q  <= 16'h0000;
            r_guess     <= 16'h0000;
            r_digit_cnt <= 3'd0;
            r_score_req <= 1'b0;
            r_strike_q  <= 4'd0;
            r_ball_q    <= 4'd0;
            r_lcd_req   <= 1'b0;
            r_try_count <= 4'd0;
            r_win       <= 1'b0;
            r_lose      <= 1'b0;
            r_dup_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_answer_q  <= w_answer_q_nxt;
            r_guess     <= w_guess_nxt;
            r_digit_cnt <= w_digit_cnt_nxt;
            r_score_req <= w_score_req_nxt;
            r_strike_q  <= w_strike_q_nxt;
            r_ball_q    <= w_ball_q_nxt;
            r_lcd_req   <= w_lcd_req_nxt;
            r_try_count <= w_try_count_nxt;
            r_win       <= w_win_nxt;
            r_lose      <= w_lose_nxt;
            r_dup_err   <= w_dup_err_nxt;
        end
    end

    assign answer_q  = r_answer_q;
    assign guess     = r_guess;
    assign digit_cnt = r_digit_cnt;
    assign score_req = r_score_req;
    assign strike_q  = r_strike_q;
    assign ball_q    = r_ball_q;
    assign lcd_req   = r_lcd_req;
    assign try_count = r_try_count;
    assign win       = r_win;
    assign lose      = r_lose;
    assign dup_err   = r_dup_err;

endmodule
`default_nettype wire
